// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, registers the ALU control code,
// forwards EX/MEM and MEM/WB results onto the ALU operands and raises load-use bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [15:0]       id_imm,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [5:0]        id_funct,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              exm_reg_write,
  input  logic [RA_W-1:0]   exm_rd,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [RA_W-1:0]   mwb_rd,
  input  logic [DATA_W-1:0] mwb_result,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] a2,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [RA_W-1:0]   ex_dest,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              load_use
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [3:0] alu_ctrl;
  } ctl_t;

  typedef struct packed {
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   dest;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
  } dat_t;

  ctl_t       ctl_q, ctl_d;
  dat_t       dat_q, dat_d;
  logic [3:0] dec_ctrl;

  always_comb begin
    dec_ctrl = 4'b0000;
    case (id_alu_op)
      2'b00: dec_ctrl = 4'b0001;
      2'b01: dec_ctrl = 4'b0010;
      2'b11: dec_ctrl = 4'b0011;
      default: begin
        case (id_funct)
          6'b100000: dec_ctrl = 4'b0001;
          6'b100010: dec_ctrl = 4'b0010;
          6'b100100: dec_ctrl = 4'b0011;
          6'b100101: dec_ctrl = 4'b0100;
          6'b100111: dec_ctrl = 4'b0101;
          6'b101010: dec_ctrl = 4'b0110;
          default:   dec_ctrl = 4'b0000;
        endcase
      end
    endcase
  end

  // Bubbles only clear control; data fields keep their old contents since nothing consumes them.
  always_comb begin
    ctl_d = ctl_q;
    dat_d = dat_q;
    if (flush || load_use) begin
      ctl_d = '0;
    end else if (!stall) begin
      ctl_d.valid      = id_valid;
      ctl_d.reg_write  = id_valid & id_reg_write;
      ctl_d.mem_read   = id_valid & id_mem_read;
      ctl_d.mem_write  = id_valid & id_mem_write;
      ctl_d.mem_to_reg = id_valid & id_mem_to_reg;
      ctl_d.branch     = id_valid & id_branch;
      ctl_d.alu_src    = id_valid & id_alu_src;
      ctl_d.alu_ctrl   = id_valid ? dec_ctrl : 4'b0000;
      dat_d.rs         = id_rs;
      dat_d.rt         = id_rt;
      dat_d.dest       = id_reg_dst ? id_rd : id_rt;
      dat_d.rs_data    = id_rs_data;
      dat_d.rt_data    = id_rt_data;
      dat_d.imm        = {{(DATA_W-16){id_imm[15]}}, id_imm};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q <= '0;
      dat_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      dat_q <= dat_d;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is hard-wired zero.
  function automatic logic [DATA_W-1:0] fwd(input logic [RA_W-1:0] r,
                                            input logic [DATA_W-1:0] d);
    if (exm_reg_write && exm_rd != '0 && exm_rd == r)      return exm_result;
    else if (mwb_reg_write && mwb_rd != '0 && mwb_rd == r) return mwb_result;
    else                                                   return d;
  endfunction

  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  assign rs_fwd = fwd(dat_q.rs, dat_q.rs_data);
  assign rt_fwd = fwd(dat_q.rt, dat_q.rt_data);

  assign a1            = rs_fwd;
  assign a2            = ctl_q.alu_src ? dat_q.imm : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_ctrl      = ctl_q.alu_ctrl;
  assign ex_dest       = dat_q.dest;
  assign ex_valid      = ctl_q.valid;
  assign ex_reg_write  = ctl_q.valid & ctl_q.reg_write;
  assign ex_mem_read   = ctl_q.valid & ctl_q.mem_read;
  assign ex_mem_write  = ctl_q.valid & ctl_q.mem_write;
  assign ex_mem_to_reg = ctl_q.valid & ctl_q.mem_to_reg;
  assign ex_branch     = ctl_q.valid & ctl_q.branch;

  assign load_use = ex_valid & ex_mem_read & (ex_dest != '0) &
                    ((ex_dest == id_rs) | (ex_dest == id_rt)) & id_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX-side outputs are queued as stimulus is
// driven and compared one cycle later (or immediately for the combinational forwarding paths).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, exm_result, mwb_result;
  logic [15:0] id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, exm_rd, mwb_rd;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
  logic        id_mem_to_reg, id_branch, exm_reg_write, mwb_reg_write;
  logic [31:0] a1, a2, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic [4:0]  ex_dest;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic        load_use;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
    .mwb_result(mwb_result), .a1(a1), .a2(a2), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .load_use(load_use)
  );

  typedef struct packed {
    logic        valid;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg, branch;
  } instr_t;

  typedef struct packed {
    logic        valid, reg_write, mem_read, mem_write, mem_to_reg, branch;
    logic [3:0]  alu_ctrl;
    logic [4:0]  dest;
    logic [31:0] a1, a2, store;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  function automatic instr_t rtype(input logic [5:0] f, input logic [4:0] rs, rt, rd,
                                   input logic [31:0] rsd, rtd);
    instr_t i = '0;
    i.valid = 1'b1; i.alu_op = 2'b10; i.funct = f;
    i.rs = rs; i.rt = rt; i.rd = rd; i.rs_data = rsd; i.rt_data = rtd;
    i.reg_dst = 1'b1; i.reg_write = 1'b1;
    return i;
  endfunction

  function automatic instr_t itype(input logic [1:0] op, input logic [4:0] rs, rt,
                                   input logic [31:0] rsd, input logic [15:0] imm);
    instr_t i = '0;
    i.valid = 1'b1; i.alu_op = op; i.rs = rs; i.rt = rt; i.rs_data = rsd; i.imm = imm;
    i.alu_src = 1'b1; i.reg_write = 1'b1;
    return i;
  endfunction

  // Reference for one captured instruction, with no forwarding in play.
  function automatic exp_t model(input instr_t i);
    exp_t       e = '0;
    logic [3:0] c;
    case (i.alu_op)
      2'b00: c = 4'd1;
      2'b01: c = 4'd2;
      2'b11: c = 4'd3;
      default: case (i.funct)
        6'b100000: c = 4'd1;
        6'b100010: c = 4'd2;
        6'b100100: c = 4'd3;
        6'b100101: c = 4'd4;
        6'b100111: c = 4'd5;
        6'b101010: c = 4'd6;
        default:   c = 4'd0;
      endcase
    endcase
    e.valid      = i.valid;
    e.reg_write  = i.valid & i.reg_write;
    e.mem_read   = i.valid & i.mem_read;
    e.mem_write  = i.valid & i.mem_write;
    e.mem_to_reg = i.valid & i.mem_to_reg;
    e.branch     = i.valid & i.branch;
    e.alu_ctrl   = i.valid ? c : 4'd0;
    e.dest       = i.reg_dst ? i.rd : i.rt;
    e.a1         = i.rs_data;
    e.store      = i.rt_data;
    e.a2         = (i.valid & i.alu_src) ? {{16{i.imm[15]}}, i.imm} : i.rt_data;
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t g;
    g.valid = ex_valid; g.reg_write = ex_reg_write; g.mem_read = ex_mem_read;
    g.mem_write = ex_mem_write; g.mem_to_reg = ex_mem_to_reg; g.branch = ex_branch;
    g.alu_ctrl = alu_ctrl; g.dest = ex_dest; g.a1 = a1; g.a2 = a2; g.store = ex_store_data;
    return g;
  endfunction

  function automatic logic [9:0] ctl(input exp_t x);
    return {x.valid, x.reg_write, x.mem_read, x.mem_write, x.mem_to_reg, x.branch, x.alu_ctrl};
  endfunction

  task automatic apply(input instr_t i);
    id_valid = i.valid; id_alu_op = i.alu_op; id_funct = i.funct;
    id_rs = i.rs; id_rt = i.rt; id_rd = i.rd; id_rs_data = i.rs_data; id_rt_data = i.rt_data;
    id_imm = i.imm; id_alu_src = i.alu_src; id_reg_dst = i.reg_dst; id_reg_write = i.reg_write;
    id_mem_read = i.mem_read; id_mem_write = i.mem_write; id_mem_to_reg = i.mem_to_reg;
    id_branch = i.branch;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input instr_t i);
    @(negedge clk);
    apply(i);
    tick();
  endtask

  task automatic test_reset();
    exp_t g;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    apply('0);
    exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
    mwb_reg_write = 1'b0; mwb_rd = '0; mwb_result = '0;
    #3;
    g = obs();
    checks++;
    if (g !== '0) $display("FAIL reset_state got=%h exp=0", g); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [5:0] fl [4] = '{6'b101010, 6'b100111, 6'b000000, 6'b100101};
    instr_t i; exp_t e, g;
    for (int k = 0; k < 4; k++) begin
      i = rtype(fl[k], 5'd1, 5'd2, 5'd4, 32'd5 + k, 32'd9 + k);
      drive(i);
      q.push_back(model(i));
      e = q.pop_front(); g = obs();
      checks++;
      if (g !== e) $display("FAIL rtype_%0d got=%h exp=%h", k, g, e); else passed++;
    end
  endtask

  task automatic test_immediate();
    logic [1:0] ops [3] = '{2'b00, 2'b01, 2'b11};
    instr_t i; exp_t e, g;
    for (int k = 0; k < 3; k++) begin
      i = itype(ops[k], 5'd1, 5'd7, 32'd100, (k == 0) ? 16'hFFFC : 16'h0123);
      drive(i);
      q.push_back(model(i));
      e = q.pop_front(); g = obs();
      checks++;
      if (g !== e) $display("FAIL imm_%0d got=%h exp=%h", k, g, e); else passed++;
    end
  endtask

  task automatic test_forwarding();
    instr_t i; exp_t e, g;
    i = rtype(6'b100000, 5'd3, 5'd5, 5'd6, 32'h11, 32'h22);
    drive(i);
    q.push_back(model(i));
    e = q.pop_front(); g = obs();
    checks++;
    if (g !== e) $display("FAIL fwd_base got=%h exp=%h", g, e); else passed++;
    @(negedge clk);
    stall = 1'b1;
    exm_reg_write = 1'b1; exm_rd = 5'd3; exm_result = 32'hAA;
    mwb_reg_write = 1'b1; mwb_rd = 5'd3; mwb_result = 32'hBB;
    #1;
    e = model(i); e.a1 = 32'hAA; q.push_back(e);
    e = q.pop_front(); g = obs();
    checks++;
    if (g !== e) $display("FAIL fwd_exm_prio got=%h exp=%h", g, e); else passed++;
    exm_reg_write = 1'b0;
    #1;
    e = model(i); e.a1 = 32'hBB; q.push_back(e);
    e = q.pop_front(); g = obs();
    checks++;
    if (g !== e) $display("FAIL fwd_mwb got=%h exp=%h", g, e); else passed++;
    exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 32'hCC;
    #1;
    e = model(i); e.a1 = 32'hBB; e.a2 = 32'hCC; e.store = 32'hCC; q.push_back(e);
    e = q.pop_front(); g = obs();
    checks++;
    if (g !== e) $display("FAIL fwd_rt_path got=%h exp=%h", g, e); else passed++;
    stall = 1'b0;
    exm_rd = 5'd0; mwb_rd = 5'd0;
    i = rtype(6'b100000, 5'd0, 5'd0, 5'd6, 32'h77, 32'h66);
    drive(i);
    q.push_back(model(i));
    e = q.pop_front(); g = obs();
    checks++;
    if (g !== e) $display("FAIL fwd_r0 got=%h exp=%h", g, e); else passed++;
    exm_reg_write = 1'b0; mwb_reg_write = 1'b0;
  endtask

  task automatic test_load_use();
    instr_t lw, add; exp_t e, g;
    lw = itype(2'b00, 5'd2, 5'd8, 32'h1000, 16'd4);
    lw.mem_read = 1'b1; lw.mem_to_reg = 1'b1;
    drive(lw);
    q.push_back(model(lw));
    e = q.pop_front(); g = obs();
    checks++;
    if (g !== e) $display("FAIL lu_load got=%h exp=%h", g, e); else passed++;
    add = rtype(6'b100000, 5'd8, 5'd9, 5'd10, 32'd0, 32'd3);
    @(negedge clk);
    apply(add);
    stall = 1'b1;
    #1;
    checks++;
    if (load_use !== 1'b1) $display("FAIL lu_detect got=%b exp=1", load_use); else passed++;
    q.push_back('0);
    tick();
    e = q.pop_front(); g = obs();
    checks++;
    if (ctl(g) !== ctl(e)) $display("FAIL lu_bubble got=%h exp=%h", ctl(g), ctl(e)); else passed++;
    checks++;
    if (load_use !== 1'b0) $display("FAIL lu_release got=%b exp=0", load_use); else passed++;
    @(negedge clk);
    stall = 1'b0;
    mwb_reg_write = 1'b1; mwb_rd = 5'd8; mwb_result = 32'hDEAD;
    e = model(add); e.a1 = 32'hDEAD; q.push_back(e);
    tick();
    e = q.pop_front(); g = obs();
    checks++;
    if (g !== e) $display("FAIL lu_replay got=%h exp=%h", g, e); else passed++;
    mwb_reg_write = 1'b0; mwb_rd = '0;
  endtask

  task automatic test_stall_flush();
    instr_t br, i; exp_t e, g;
    br = itype(2'b01, 5'd1, 5'd2, 32'd7, 16'd0);
    br.alu_src = 1'b0; br.reg_write = 1'b0; br.branch = 1'b1; br.rt_data = 32'd8;
    drive(br);
    q.push_back(model(br));
    e = q.pop_front(); g = obs();
    checks++;
    if (g !== e) $display("FAIL sf_branch got=%h exp=%h", g, e); else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stall = 1'b1;
      apply(rtype(6'b100100, 5'd11, 5'd12, 5'd13, k, k));
      q.push_back(model(br));
      tick();
      e = q.pop_front(); g = obs();
      checks++;
      if (g !== e) $display("FAIL sf_hold_%0d got=%h exp=%h", k, g, e); else passed++;
    end
    @(negedge clk);
    flush = 1'b1;
    q.push_back('0);
    tick();
    e = q.pop_front(); g = obs();
    checks++;
    if (ctl(g) !== ctl(e)) $display("FAIL sf_flush got=%h exp=%h", ctl(g), ctl(e)); else passed++;
    @(negedge clk);
    flush = 1'b0; stall = 1'b0;
    i = rtype(6'b100010, 5'd4, 5'd5, 5'd6, 32'h40, 32'h50);
    i.valid = 1'b0;
    drive(i);
    q.push_back(model(i));
    e = q.pop_front(); g = obs();
    checks++;
    if (g !== e) $display("FAIL sf_invalid got=%h exp=%h", g, e); else passed++;
  endtask

  task automatic test_reset_midstream();
    instr_t i; exp_t e, g;
    i = rtype(6'b100000, 5'd1, 5'd2, 5'd3, 32'd4, 32'd5);
    drive(i);
    q.push_back(model(i));
    e = q.pop_front(); g = obs();
    checks++;
    if (g !== e) $display("FAIL mid_add got=%h exp=%h", g, e); else passed++;
    #2 rst_n = 1'b0;
    #1;
    g = obs();
    checks++;
    if (g !== '0) $display("FAIL mid_reset got=%h exp=0", g); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_immediate();
    test_forwarding();
    test_load_use();
    test_stall_flush();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-preparation stage sitting directly upstream of the ALU.
- Each cycle it captures decoded instruction fields and register-file operands from the decode stage.
- It registers a 4-bit ALU control code derived from ALUOp/funct, and drives the ALU's a1/a2/alu_ctrl inputs after EX/MEM and MEM/WB forwarding.
- It also detects load-use hazards, inserts a bubble when one occurs, and supports stall and flush.

Parameters:
- DATA_W, 32: operand/result width.
- RA_W, 5: register address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold stage contents (downstream back-pressure)
- flush  in  1  squash stage (branch redirect)
- id_valid  in  1  decode slot holds a real instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  16  raw immediate
- id_rs, id_rt, id_rd  in  RA_W  register specifiers
- id_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 and
- id_funct  in  6  R-type funct field
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  decode controls
- exm_reg_write  in  1, exm_rd  in  RA_W, exm_result  in  DATA_W  EX/MEM forwarding source
- mwb_reg_write  in  1, mwb_rd  in  RA_W, mwb_result  in  DATA_W  MEM/WB forwarding source
- a1, a2  out  DATA_W  ALU operands
- alu_ctrl  out  4  ALU operation code
- ex_store_data  out  DATA_W  forwarded rt value for stores
- ex_dest  out  RA_W  write-back register (rd if reg_dst else rt)
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each
- load_use  out  1  hazard request to hold PC and IF/ID

Behaviour:
- Reset (rst_n low, asynchronous): every stage register is cleared to 0.
  - Outputs read ex_valid=0, alu_ctrl=0000, all controls 0, ex_dest=0, a1=a2=ex_store_data=0 (forwarding inputs are don't-care because all held registers are 0).
  - Release is synchronous to the next rising edge.
- Capture priority at each rising edge: flush > load_use bubble > stall hold > normal load.
  - flush=1: clear ex_valid and every control bit; data fields don't-care.
  - load_use=1 (and no flush): insert a bubble, same as flush. Decode must present the same instruction again next cycle.
  - stall=1 (no flush, no load_use): all registers hold.
  - Otherwise: load all id_* fields, qualifying every control bit with id_valid.
- Bubble outputs: ex_reg_write, ex_mem_read, ex_mem_write, ex_branch are always 0 when ex_valid=0; alu_ctrl is registered 0000.
- alu_ctrl decode (registered at capture):
  - alu_op 00 -> 0001; 01 -> 0010; 11 -> 0011.
  - alu_op 10 by funct: 100000 -> 0001, 100010 -> 0010, 100100 -> 0011, 100101 -> 0100, 100111 -> 0101, 101010 -> 0110. Any other funct -> 0000.
- Immediate: sign-extend id_imm to DATA_W at capture.
- Forwarding is combinational from the registered rs/rt and their data, applied separately to the rs and rt paths:
  - An EX/MEM match (exm_reg_write, exm_rd nonzero, exm_rd equal to the register) takes priority.
  - Otherwise a MEM/WB match under the same conditions.
  - Otherwise the registered register-file value.
  - Register 0 is never forwarded.
- Operand outputs: a1 = forwarded rs. ex_store_data = forwarded rt. a2 = sign-extended immediate if alu_src, else forwarded rt.
- load_use (combinational) = ex_valid & ex_mem_read & ex_dest nonzero & (ex_dest==id_rs | ex_dest==id_rt) & id_valid.
- stall with a simultaneous load_use: the bubble wins, because the consumer must not enter EX.
- Latency: one cycle from id_* to registered outputs; forwarding adds zero cycles.

Test Plan:
- Reset mid-stream: drive an add, assert rst_n low between edges -> outputs clear immediately; alu_ctrl=0000, ex_valid=0, ex_reg_write=0.
- R-type decode: alu_op=10, funct=101010, rs_data=5, rt_data=9 -> next cycle a1=5, a2=9, alu_ctrl=0110. Repeat for funct 100111 -> 0101, and funct 000000 -> 0000.
- Immediate: alu_op=00, alu_src=1, imm=16'hFFFC, rs_data=100 -> a2=32'hFFFFFFFC, alu_ctrl=0001.
- Forwarding priority: registered rs=3; exm_rd=3, exm_result=0xAA; mwb_rd=3, mwb_result=0xBB, both write enables=1 -> a1=0xAA. Drop exm_reg_write -> a1=0xBB. Set rs=0 with matching rd=0 -> a1=registered value.
- Load-use: lw into r8 in EX, decode add with rs=8 -> load_use=1, next cycle ex_valid=0 and alu_ctrl=0000; the following cycle the add enters with a1 forwarded from mwb_result.
- Stall/flush: stall=1 for 3 cycles -> outputs unchanged. flush=1 together with stall=1 -> ex_valid=0 and ex_branch=0 next cycle.
